// File: rtl/calc2_pkg.sv
// calc2_pkg: shared types and sizing for the calc2 four-port calculator
package calc2_pkg;
  localparam int DATA_W = 32;
  localparam int QDEPTH = 4;
  localparam int QAW = $clog2(QDEPTH);
  localparam int CNTW = $clog2(QDEPTH + 1);
  typedef enum logic [3:0] {
    CMD_NONE = 4'd0,
    CMD_ADD  = 4'd1,
    CMD_SUB  = 4'd2,
    CMD_SHL  = 4'd5,
    CMD_SHR  = 4'd6
  } cmd_e;
  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_OK   = 2'd1,
    RESP_ERR  = 2'd2
  } resp_e;
  typedef enum logic {
    CAP_IDLE,
    CAP_OP2
  } cap_e;
  typedef struct packed {
    logic [3:0]        cmd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [1:0]        tag;
  } req_t;
endpackage

// File: rtl/calc2_port_in.sv
// calc2_port_in: per-port two-cycle command capture feeding a QDEPTH-entry FIFO
module calc2_port_in
  import calc2_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [3:0]        i_cmd,
  input  logic [DATA_W-1:0] i_data,
  input  logic [1:0]        i_tag,
  input  logic              i_pop,
  output logic              o_valid,
  output req_t              o_head
);
  cap_e              r_state;
  cap_e              w_next;
  logic              w_latch;
  logic              w_push;
  logic [3:0]        r_cmd;
  logic [DATA_W-1:0] r_op1;
  logic [1:0]        r_tag;
  req_t              r_mem [QDEPTH];
  logic [QAW-1:0]    r_wp;
  logic [QAW-1:0]    r_rp;
  logic [CNTW-1:0]   r_count;
  // capture state register
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_state <= CAP_IDLE;
    else r_state <= w_next;
  // a nonzero command in IDLE starts a transfer; operand 2 always follows next cycle
  always_comb w_next = (r_state == CAP_IDLE && i_cmd != 4'd0) ? CAP_OP2 : CAP_IDLE;
  // latch the first half in IDLE; push the whole command in OP2 unless the FIFO is full
  always_comb begin
    w_latch = r_state == CAP_IDLE && i_cmd != 4'd0;
    w_push  = r_state == CAP_OP2 && r_count != CNTW'(QDEPTH);
  end
  // hold command, operand 1 and tag across the OP2 cycle
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_cmd <= '0;
      r_op1 <= '0;
      r_tag <= '0;
    end else if (w_latch) begin
      r_cmd <= i_cmd;
      r_op1 <= i_data;
      r_tag <= i_tag;
    end
  // FIFO pointers and occupancy; a push and a pop may coincide
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + QAW'(1);
      if (i_pop) r_rp <= r_rp + QAW'(1);
      r_count <= r_count + CNTW'(w_push) - CNTW'(i_pop);
    end
  // FIFO storage; occupancy gates every read so no reset is needed
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wp] <= {r_cmd, r_op1, i_data, r_tag};
  assign o_valid = r_count != '0;
  assign o_head  = r_mem[r_rp];
endmodule

// File: rtl/calc2_top.sv
// calc2_top: four-port tagged calculator, round-robin onto one ALU (shifter gated by CALC2_SHIFT_EN)
module calc2_top
  import calc2_pkg::*;
(
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req1_cmd_in,
  input  logic [DATA_W-1:0] req1_data_in,
  input  logic [1:0]        req1_tag_in,
  input  logic [3:0]        req2_cmd_in,
  input  logic [DATA_W-1:0] req2_data_in,
  input  logic [1:0]        req2_tag_in,
  input  logic [3:0]        req3_cmd_in,
  input  logic [DATA_W-1:0] req3_data_in,
  input  logic [1:0]        req3_tag_in,
  input  logic [3:0]        req4_cmd_in,
  input  logic [DATA_W-1:0] req4_data_in,
  input  logic [1:0]        req4_tag_in,
  output logic [1:0]        out_resp1,
  output logic [DATA_W-1:0] out_data1,
  output logic [1:0]        out_tag1,
  output logic [1:0]        out_resp2,
  output logic [DATA_W-1:0] out_data2,
  output logic [1:0]        out_tag2,
  output logic [1:0]        out_resp3,
  output logic [DATA_W-1:0] out_data3,
  output logic [1:0]        out_tag3,
  output logic [1:0]        out_resp4,
  output logic [DATA_W-1:0] out_data4,
  output logic [1:0]        out_tag4
);
  logic [3:0]        w_cmd  [4];
  logic [DATA_W-1:0] w_data [4];
  logic [1:0]        w_tag  [4];
  req_t              w_head [4];
  logic [3:0]        w_valid;
  logic [3:0]        w_pop;
  logic              w_gnt_vld;
  logic [1:0]        w_gnt;
  logic [1:0]        w_idx;
  logic [1:0]        r_last;
  logic              r_vld;
  logic [1:0]        r_port;
  req_t              r_req;
  logic [DATA_W:0]   w_sum;
  logic              w_ok;
  logic [DATA_W-1:0] w_val;
  logic [1:0]        r_resp [4];
  logic [DATA_W-1:0] r_data [4];
  logic [1:0]        r_tag  [4];
  assign w_cmd  = '{req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in};
  assign w_data = '{req1_data_in, req2_data_in, req3_data_in, req4_data_in};
  assign w_tag  = '{req1_tag_in, req2_tag_in, req3_tag_in, req4_tag_in};
  for (genvar g = 0; g < 4; g++) begin : g_port
    calc2_port_in u_port (
      .i_clk  (c_clk),
      .i_rst  (reset),
      .i_cmd  (w_cmd[g]),
      .i_data (w_data[g]),
      .i_tag  (w_tag[g]),
      .i_pop  (w_pop[g]),
      .o_valid(w_valid[g]),
      .o_head (w_head[g])
    );
  end
  // round-robin: scan from the port after the last grant, lowest offset wins
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = r_last;
    w_idx     = r_last;
    for (int k = 4; k >= 1; k--) begin
      w_idx = r_last + 2'(k);
      if (w_valid[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_idx;
      end
    end
  end
  assign w_pop = w_gnt_vld ? 4'b0001 << w_gnt : 4'b0000;
  // grant stage: pop the winning head into the ALU operand register
  always_ff @(posedge c_clk or posedge reset)
    if (reset) begin
      r_vld  <= 1'b0;
      r_port <= '0;
      r_req  <= '0;
      r_last <= 2'd3;
    end else begin
      r_vld  <= w_gnt_vld;
      r_port <= w_gnt;
      r_req  <= w_head[w_gnt];
      if (w_gnt_vld) r_last <= w_gnt;
    end
  // ALU: unsigned add/sub with carry/borrow as error, optional logical shifts
  always_comb begin
    w_sum = {1'b0, r_req.op1} + {1'b0, r_req.op2};
`ifdef CALC2_SHIFT_EN
    w_ok  = (r_req.cmd == CMD_ADD && !w_sum[DATA_W]) || (r_req.cmd == CMD_SUB && r_req.op1 >= r_req.op2) ||
            r_req.cmd == CMD_SHL || r_req.cmd == CMD_SHR;
    w_val = r_req.cmd == CMD_ADD ? w_sum[DATA_W-1:0] :
            r_req.cmd == CMD_SUB ? r_req.op1 - r_req.op2 :
            r_req.cmd == CMD_SHL ? r_req.op1 << r_req.op2[4:0] : r_req.op1 >> r_req.op2[4:0];
`else
    w_ok  = (r_req.cmd == CMD_ADD && !w_sum[DATA_W]) || (r_req.cmd == CMD_SUB && r_req.op1 >= r_req.op2);
    w_val = r_req.cmd == CMD_ADD ? w_sum[DATA_W-1:0] : r_req.op1 - r_req.op2;
`endif
  end
  // output registers: only the originating port responds, for one cycle
  always_ff @(posedge c_clk or posedge reset)
    if (reset) begin
      r_resp <= '{default: '0};
      r_data <= '{default: '0};
      r_tag  <= '{default: '0};
    end else begin
      for (int p = 0; p < 4; p++) begin
        r_resp[p] <= (r_vld && r_port == 2'(p)) ? (w_ok ? RESP_OK : RESP_ERR) : RESP_NONE;
        r_data[p] <= (r_vld && r_port == 2'(p) && w_ok) ? w_val : '0;
        r_tag[p]  <= (r_vld && r_port == 2'(p)) ? r_req.tag : 2'd0;
      end
    end
  assign out_resp1 = r_resp[0];
  assign out_data1 = r_data[0];
  assign out_tag1  = r_tag[0];
  assign out_resp2 = r_resp[1];
  assign out_data2 = r_data[1];
  assign out_tag2  = r_tag[1];
  assign out_resp3 = r_resp[2];
  assign out_data3 = r_data[2];
  assign out_tag3  = r_tag[2];
  assign out_resp4 = r_resp[3];
  assign out_data4 = r_data[3];
  assign out_tag4  = r_tag[3];
endmodule

// File: tb/tb_calc2_top.sv
// tb_calc2_top: directed table, contention, reset and randomized scoreboard checks for calc2_top
module tb_calc2_top;
  logic        c_clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  cmd  [4];
  logic [31:0] din  [4];
  logic [1:0]  tin  [4];
  logic [1:0]  o_resp [4];
  logic [31:0] o_data [4];
  logic [1:0]  o_tag  [4];
  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
  } exp_t;
  typedef struct {
    int          p;
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  t;
    logic [1:0]  r;
    logic [31:0] d;
  } vec_t;
`ifdef CALC2_SHIFT_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif
  exp_t exp_q [4][64];
  int   wr [4];
  int   rd [4];
  int   drv_checks = 0, drv_fails = 0, mon_checks = 0, mon_fails = 0;

  always #5 c_clk = ~c_clk;

  calc2_top dut (
    .c_clk(c_clk), .reset(reset),
    .req1_cmd_in(cmd[0]), .req1_data_in(din[0]), .req1_tag_in(tin[0]),
    .req2_cmd_in(cmd[1]), .req2_data_in(din[1]), .req2_tag_in(tin[1]),
    .req3_cmd_in(cmd[2]), .req3_data_in(din[2]), .req3_tag_in(tin[2]),
    .req4_cmd_in(cmd[3]), .req4_data_in(din[3]), .req4_tag_in(tin[3]),
    .out_resp1(o_resp[0]), .out_data1(o_data[0]), .out_tag1(o_tag[0]),
    .out_resp2(o_resp[1]), .out_data2(o_data[1]), .out_tag2(o_tag[1]),
    .out_resp3(o_resp[2]), .out_data3(o_data[2]), .out_tag3(o_tag[2]),
    .out_resp4(o_resp[3]), .out_data4(o_data[3]), .out_tag4(o_tag[3])
  );

  // reference: results from the arithmetic rules, no pipeline knowledge
  function automatic exp_t model(logic [3:0] c, logic [31:0] a, logic [31:0] b, logic [1:0] t);
    exp_t e;
    logic [63:0] s;
    e.resp = 2'd2; e.data = 32'd0; e.tag = t;
    s = 64'(a) + 64'(b);
    if (c == 4'd1 && s <= 64'hFFFF_FFFF) begin e.resp = 2'd1; e.data = s[31:0]; end
    else if (c == 4'd2 && a >= b) begin e.resp = 2'd1; e.data = a - b; end
    else if (SH && c == 4'd5) begin e.resp = 2'd1; e.data = a << (b % 32); end
    else if (SH && c == 4'd6) begin e.resp = 2'd1; e.data = a >> (b % 32); end
    return e;
  endfunction

  // scoreboard monitor: every response must match the oldest expectation on its port
  always @(negedge c_clk) begin
    int  n;
    logic bad;
    if (!reset) begin
      n = 0; bad = 1'b0;
      for (int p = 0; p < 4; p++) begin
        if (o_resp[p] != 2'd0) n++;
        else if (o_data[p] != 32'd0 || o_tag[p] != 2'd0) bad = 1'b1;
      end
      mon_checks++;
      if (n > 1 || bad) begin
        mon_fails++;
        $display("FAIL cycle_shape: got %0d responders idle_nonzero=%0d, want <=1 and 0", n, bad);
      end
      for (int p = 0; p < 4; p++) if (o_resp[p] != 2'd0) begin
        mon_checks++;
        if (rd[p] == wr[p]) begin
          mon_fails++;
          $display("FAIL unexpected_p%0d: got resp=%0d data=%h tag=%0d, want no response", p + 1, o_resp[p], o_data[p], o_tag[p]);
        end else begin
          exp_t e;
          e = exp_q[p][rd[p] % 64];
          if (o_resp[p] !== e.resp || o_data[p] !== e.data || o_tag[p] !== e.tag) begin
            mon_fails++;
            $display("FAIL resp_p%0d: got resp=%0d data=%h tag=%0d, want resp=%0d data=%h tag=%0d",
                     p + 1, o_resp[p], o_data[p], o_tag[p], e.resp, e.data, e.tag);
          end
          rd[p]++;
        end
      end
    end
  end

  task automatic chk(string name, logic [63:0] got, logic [63:0] want);
    drv_checks++;
    if (got !== want) begin
      drv_fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic push_exp(int p, exp_t e);
    exp_q[p][wr[p] % 64] = e;
    wr[p]++;
  endtask

  // two-cycle transfer; returns at the negedge after the operand-2 edge
  task automatic send(int p, logic [3:0] c, logic [31:0] a, logic [31:0] b, logic [1:0] t);
    cmd[p] = c; din[p] = a; tin[p] = t;
    @(negedge c_clk);
    cmd[p] = 4'hF; din[p] = b; tin[p] = ~t;
    @(negedge c_clk);
    cmd[p] = 4'd0; din[p] = 32'd0; tin[p] = 2'd0;
  endtask

  // single command with exact latency check: silent after T+2, response after T+3
  task automatic run_vec(vec_t v);
    push_exp(v.p, '{v.r, v.d, v.t});
    send(v.p, v.c, v.a, v.b, v.t);
    @(negedge c_clk);
    chk($sformatf("early_p%0d", v.p + 1), 64'(o_resp[v.p]), 64'd0);
    @(negedge c_clk);
    chk($sformatf("resp_p%0d_c%0d", v.p + 1, v.c), 64'(o_resp[v.p]), 64'(v.r));
    chk($sformatf("data_p%0d_c%0d", v.p + 1, v.c), 64'(o_data[v.p]), 64'(v.d));
    chk($sformatf("tag_p%0d_c%0d", v.p + 1, v.c), 64'(o_tag[v.p]), 64'(v.t));
    @(negedge c_clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [11];
    logic [3:0]  cmds [8];
    int          phase [4];
    logic [3:0]  pc [4];
    logic [31:0] pa [4];
    logic [31:0] pb [4];
    logic [1:0]  pt [4];
    int          cnt;
    vecs[0]  = '{0, 4'd1, 32'h30, 32'h20, 2'd1, 2'd1, 32'h50};
    vecs[1]  = '{0, 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2, 2'd2, 32'h0};
    vecs[2]  = '{1, 4'd2, 32'd5, 32'd6, 2'd0, 2'd2, 32'h0};
    vecs[3]  = '{1, 4'd2, 32'd6, 32'd5, 2'd2, 2'd1, 32'h1};
    vecs[4]  = '{2, 4'd5, 32'h1, 32'h21, 2'd1, SH ? 2'd1 : 2'd2, SH ? 32'h2 : 32'h0};
    vecs[5]  = '{3, 4'd6, 32'h8000_0000, 32'd31, 2'd3, SH ? 2'd1 : 2'd2, SH ? 32'h1 : 32'h0};
    vecs[6]  = '{1, 4'd3, 32'h10, 32'h20, 2'd3, 2'd2, 32'h0};
    vecs[7]  = '{0, 4'd1, 32'h7FFF_FFFF, 32'h8000_0000, 2'd0, 2'd1, 32'hFFFF_FFFF};
    vecs[8]  = '{2, 4'd2, 32'd0, 32'd0, 2'd2, 2'd1, 32'h0};
    vecs[9]  = '{3, 4'd7, 32'h5, 32'h5, 2'd0, 2'd2, 32'h0};
    vecs[10] = '{0, 4'd5, 32'hFFFF_FFFF, 32'd0, 2'd1, SH ? 2'd1 : 2'd2, SH ? 32'hFFFF_FFFF : 32'h0};
    cmds = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd5, 4'd6, 4'd3, 4'd9};
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 4'd0; din[p] = 32'd0; tin[p] = 2'd0; wr[p] = 0; rd[p] = 0; phase[p] = 0;
    end
    @(negedge c_clk);
    @(negedge c_clk);
    for (int p = 0; p < 4; p++)
      chk($sformatf("reset_p%0d", p + 1), {o_resp[p], o_data[p], o_tag[p]}, 64'd0);
    reset = 1'b0;
    @(negedge c_clk);

    // all four ports in the same cycle: responses in port order, consecutive cycles
    for (int p = 0; p < 4; p++) begin
      push_exp(p, '{2'd1, 32'h100 * (p + 1) + 32'(p + 1), 2'(3 - p)});
      cmd[p] = 4'd1; din[p] = 32'h100 * (p + 1); tin[p] = 2'(3 - p);
    end
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) begin cmd[p] = 4'd0; din[p] = 32'(p + 1); end
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) din[p] = 32'd0;
    @(negedge c_clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge c_clk);
      chk($sformatf("rr_resp_p%0d", k + 1), 64'(o_resp[k]), 64'd1);
      chk($sformatf("rr_data_p%0d", k + 1), 64'(o_data[k]), 64'h100 * (k + 1) + 64'(k + 1));
      chk($sformatf("rr_tag_p%0d", k + 1), 64'(o_tag[k]), 64'(3 - k));
    end
    @(negedge c_clk);

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // reset with one response visible and a second command queued on port 3
    push_exp(2, '{2'd1, 32'd15, 2'd1});
    send(2, 4'd1, 32'd7, 32'd8, 2'd1);
    cmd[2] = 4'd1; din[2] = 32'd100; tin[2] = 2'd2;
    push_exp(2, '{2'd1, 32'd300, 2'd2});
    @(negedge c_clk);
    cmd[2] = 4'd0; din[2] = 32'd200;
    @(negedge c_clk);
    din[2] = 32'd0; tin[2] = 2'd0;
    chk("rst_pre_resp_p3", 64'(o_resp[2]), 64'd1);
    #2 reset = 1'b1;
    #1;
    for (int p = 0; p < 4; p++)
      chk($sformatf("rst_async_p%0d", p + 1), {o_resp[p], o_data[p], o_tag[p]}, 64'd0);
    wr[2] = rd[2];
    @(negedge c_clk);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge c_clk);
      for (int p = 0; p < 4; p++) if (o_resp[p] != 2'd0) cnt++;
    end
    chk("rst_no_resp", 64'(cnt), 64'd0);
    run_vec('{2, 4'd1, 32'h30, 32'h20, 2'd3, 2'd1, 32'h50});

    // randomized traffic, at most four outstanding per port
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int p = 0; p < 4; p++) begin
        if (phase[p] != 0) begin
          cmd[p] = 4'($urandom); din[p] = pb[p]; tin[p] = 2'($urandom);
          push_exp(p, model(pc[p], pa[p], pb[p], pt[p]));
          phase[p] = 0;
        end else if (wr[p] - rd[p] < 4 && $urandom_range(0, 2) != 0) begin
          pc[p] = cmds[$urandom_range(0, 7)];
          pa[p] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
          pb[p] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
          pt[p] = 2'($urandom);
          cmd[p] = pc[p]; din[p] = pa[p]; tin[p] = pt[p];
          phase[p] = 1;
        end else begin
          cmd[p] = 4'd0; din[p] = $urandom; tin[p] = 2'($urandom);
        end
      end
      @(negedge c_clk);
    end
    for (int p = 0; p < 4; p++) begin
      if (phase[p] != 0) begin
        din[p] = pb[p];
        push_exp(p, model(pc[p], pa[p], pb[p], pt[p]));
      end
      cmd[p] = 4'd0;
    end
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) begin din[p] = 32'd0; tin[p] = 2'd0; end
    for (int w = 0; w < 200 && (wr[0] != rd[0] || wr[1] != rd[1] || wr[2] != rd[2] || wr[3] != rd[3]); w++)
      @(negedge c_clk);
    @(negedge c_clk);
    for (int p = 0; p < 4; p++)
      chk($sformatf("drain_p%0d", p + 1), 64'(wr[p] - rd[p]), 64'd0);

    $display("%0d/%0d checks passed", (drv_checks + mon_checks) - (drv_fails + mon_fails), drv_checks + mon_checks);
    $finish;
  end
endmodule
